// File: rtl/bsg_mem_1rw_sync_mask_write_bit_client.sv
// Client front-end for a 1rw sync bit-masked RAM: valid/ready requests in, valid/yumi responses out.
// Optional macro BSG_MEM_1RW_CLIENT_WRITE_ACK_EN: writes also return an ack response, flagged on w_o.
module bsg_mem_1rw_sync_mask_write_bit_client #(
  parameter  int width_p       = 1,
  parameter  int els_p         = 1,
  parameter  int resp_els_p    = 2,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,

  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
`ifdef BSG_MEM_1RW_CLIENT_WRITE_ACK_EN
  output logic                     w_o,
`endif
  input  logic                     yumi_i,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  localparam int cnt_w_lp = $clog2(resp_els_p + 1);
  localparam int ptr_w_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;

  // rd_inflight_q: a response arrives from the RAM side this cycle
  logic                rd_inflight_q, rd_inflight_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [ptr_w_lp-1:0] head_q, head_d, tail_q, tail_d;
  logic [width_p-1:0]  buf_data_q [resp_els_p];

  logic                empty, push, pop;
  logic [cnt_w_lp:0]   credits_used;
  logic [width_p-1:0]  arrive_data;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(resp_els_p - 1)) return '0;
    else                                return p + 1'b1;
  endfunction

  // Issue path: straight through, gated only by registered credits
  assign credits_used = {1'b0, count_q} + (cnt_w_lp + 1)'(rd_inflight_q);
  assign ready_o      = ~reset_i & (credits_used < (cnt_w_lp + 1)'(resp_els_p));
  assign mem_v_o      = v_i & ready_o;
  assign mem_w_o      = w_i;
  assign mem_addr_o   = addr_i;
  assign mem_data_o   = data_i;
  assign mem_w_mask_o = w_mask_i;

`ifdef BSG_MEM_1RW_CLIENT_WRITE_ACK_EN
  logic wr_inflight_q, wr_inflight_d;
  logic buf_w_q [resp_els_p];

  assign rd_inflight_d = mem_v_o;
  assign wr_inflight_d = mem_v_o & mem_w_o;
  assign arrive_data   = wr_inflight_q ? '0 : mem_data_i;
  assign w_o           = empty ? wr_inflight_q : buf_w_q[head_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) wr_inflight_q <= 1'b0;
    else         wr_inflight_q <= wr_inflight_d;
  end

  always_ff @(posedge clk_i) begin
    if (push) buf_w_q[tail_q] <= wr_inflight_q;
  end
`else
  assign rd_inflight_d = mem_v_o & ~mem_w_o;
  assign arrive_data   = mem_data_i;
`endif

  // Response side: bypass RAM output when the buffer is empty
  assign empty  = (count_q == '0);
  assign v_o    = ~reset_i & (~empty | rd_inflight_q);
  assign data_o = empty ? arrive_data : buf_data_q[head_q];
  assign pop    = yumi_i & ~empty;
  assign push   = rd_inflight_q & ~(empty & yumi_i);

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    if (push & ~pop) count_d = count_q + 1'b1;
    else if (pop & ~push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_inflight_q <= 1'b0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) buf_data_q[tail_q] <= arrive_data;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(push && count_q == cnt_w_lp'(resp_els_p)));
      assert (!(yumi_i && !v_o));
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_client.sv
// Directed bench for the 1rw masked-write RAM client, with a behavioural RAM behind the mem_* port.
module tb_bsg_mem_1rw_sync_mask_write_bit_client;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       v_i, w_i, yumi_i;
  logic       ready_o, v_o;
  logic [3:0] addr_i;
  logic [7:0] data_i, w_mask_i, data_o;
  logic       mem_v_o, mem_w_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_o, mem_w_mask_o, mem_data_i;
`ifdef BSG_MEM_1RW_CLIENT_WRITE_ACK_EN
  logic       w_o;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  bsg_mem_1rw_sync_mask_write_bit_client #(
    .width_p(8), .els_p(16), .resp_els_p(2)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .ready_o(ready_o), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .w_mask_i(w_mask_i),
    .v_o(v_o), .data_o(data_o),
`ifdef BSG_MEM_1RW_CLIENT_WRITE_ACK_EN
    .w_o(w_o),
`endif
    .yumi_i(yumi_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // Behavioural 1rw RAM: write at posedge, read data registered for the next cycle
  logic [7:0] ram [16] = '{default: 8'h00};
  logic [7:0] ram_rdata = 8'h00;
  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
      else         ram_rdata <= ram[mem_addr_o];
    end
  end
  assign mem_data_i = ram_rdata;

  typedef struct {
    logic       v, w;
    logic [3:0] addr;
    logic [7:0] data, mask;
    logic       yumi;
    logic       e_ready, e_v, chk_data;
    logic [7:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic w, input logic [3:0] a,
                              input logic [7:0] d, input logic [7:0] m, input logic y,
                              input logic er, input logic ev, input logic cd, input logic [7:0] ed);
    vec_t r;
    r.v = v; r.w = w; r.addr = a; r.data = d; r.mask = m; r.yumi = y;
    r.e_ready = er; r.e_v = ev; r.chk_data = cd; r.e_data = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic w, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] m, input logic y);
    v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m; yumi_i = y;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    vec_t vecs[9];
    int   issued, got, first_acc, first_resp, last_resp, cyc;
    logic rdy_drop, stale, r, vv;
    logic [7:0] d;

    reset_i = 1'b1;
    idle();
    repeat (2) @(negedge clk_i);
    drive(1'b1, 1'b0, 4'd1, 8'h00, 8'h00, 1'b0);
    #1;
    check("reset_ready", 32'(ready_o), 32'd0);
    check("reset_v_o", 32'(v_o), 32'd0);
    check("reset_mem_v", 32'(mem_v_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    idle();
    #1;
    check("post_reset_ready", 32'(ready_o), 32'd1);
    check("post_reset_v_o", 32'(v_o), 32'd0);

`ifdef BSG_MEM_1RW_CLIENT_WRITE_ACK_EN
    // Write then read: ack first, then read data
    @(negedge clk_i);
    drive(1'b1, 1'b1, 4'd7, 8'h3C, 8'hFF, 1'b0);
    #1;
    check("ack_wr_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    drive(1'b1, 1'b0, 4'd7, 8'h00, 8'h00, 1'b0);
    #1;
    check("ack_rd_ready", 32'(ready_o), 32'd1);
    check("ack_v", 32'(v_o), 32'd1);
    check("ack_w", 32'(w_o), 32'd1);
    check("ack_data", 32'(data_o), 32'd0);
    yumi_i = v_o;
    @(negedge clk_i);
    idle();
    #1;
    check("ack_rd_v", 32'(v_o), 32'd1);
    check("ack_rd_w", 32'(w_o), 32'd0);
    check("ack_rd_data", 32'(data_o), 32'h3C);
    yumi_i = v_o;
    @(negedge clk_i);
    idle();
    #1;
    check("ack_drained", 32'(v_o), 32'd0);
`else
    vecs[0] = mk(1'b1, 1'b1, 4'd3, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    vecs[1] = mk(1'b1, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    vecs[2] = mk(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    vecs[3] = mk(1'b1, 1'b1, 4'd5, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    vecs[4] = mk(1'b1, 1'b1, 4'd5, 8'hA5, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    vecs[5] = mk(1'b1, 1'b0, 4'd5, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    vecs[6] = mk(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05);
    vecs[7] = mk(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05);
    vecs[8] = mk(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      drive(vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].yumi);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_mem_v", i), 32'(mem_v_o), 32'(vecs[i].v & vecs[i].e_ready));
      check($sformatf("vec%0d_v_o", i), 32'(v_o), 32'(vecs[i].e_v));
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), 32'(data_o), 32'(vecs[i].e_data));
    end

    // Back-to-back reads with the client stalled, then drained in order
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b1, 4'(i), 8'(8'h10 + i), 8'hFF, 1'b0);
    end
    issued = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b0, 4'(issued), 8'h00, 8'h00, 1'b0);
      #1;
      if (ready_o) issued++;
    end
    check("b2b_accepts_stalled", 32'(issued), 32'd2);
    check("b2b_ready_low", 32'(ready_o), 32'd0);
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk_i);
      drive(issued < 4, 1'b0, 4'(issued), 8'h00, 8'h00, yumi_i);
      #1;
      r = ready_o; vv = v_o; d = data_o;
      yumi_i = vv;
      if (v_i && r) issued++;
      if (vv) begin
        check($sformatf("b2b_order%0d", got), 32'(d), 32'(8'h10 + got));
        got++;
      end
    end
    check("b2b_resp_count", 32'(got), 32'd4);
    stale = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      idle();
      #1;
      if (v_o) stale = 1'b1;
    end
    check("b2b_no_dup", 32'(stale), 32'd0);

    // Streaming: 16 reads with the client always consuming
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b1, 4'(i), 8'(i * 7 + 3), 8'hFF, 1'b0);
    end
    issued = 0; got = 0; first_acc = -1; first_resp = -1; last_resp = -1;
    rdy_drop = 1'b0;
    for (cyc = 0; cyc < 60 && got < 16; cyc++) begin
      @(negedge clk_i);
      drive(issued < 16, 1'b0, 4'(issued), 8'h00, 8'h00, yumi_i);
      #1;
      r = ready_o; vv = v_o; d = data_o;
      yumi_i = vv;
      if (!r) rdy_drop = 1'b1;
      if (v_i && r) begin
        if (first_acc < 0) first_acc = cyc;
        issued++;
      end
      if (vv) begin
        if (first_resp < 0) first_resp = cyc;
        last_resp = cyc;
        check($sformatf("stream_data%0d", got), 32'(d), 32'(8'(got * 7 + 3)));
        got++;
      end
    end
    check("stream_ready_held", 32'(rdy_drop), 32'd0);
    check("stream_count", 32'(got), 32'd16);
    check("stream_first_latency", 32'(first_resp - first_acc), 32'd1);
    check("stream_one_per_cycle", 32'(last_resp - first_resp), 32'd15);
`endif

    // Reset with one read inflight and one entry buffered
    @(negedge clk_i);
    drive(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    #1;
    check("rst_mid_acc0", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    drive(1'b1, 1'b0, 4'd1, 8'h00, 8'h00, 1'b0);
    #1;
    check("rst_mid_acc1", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    reset_i = 1'b1;
    drive(1'b1, 1'b0, 4'd2, 8'h00, 8'h00, 1'b0);
    #1;
    check("rst_mid_ready", 32'(ready_o), 32'd0);
    check("rst_mid_v_o", 32'(v_o), 32'd0);
    check("rst_mid_mem_v", 32'(mem_v_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    idle();
    #1;
    check("rst_after_v_o", 32'(v_o), 32'd0);
    check("rst_after_ready", 32'(ready_o), 32'd1);
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      idle();
      #1;
      if (v_o) stale = 1'b1;
    end
    check("rst_no_stale", 32'(stale), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
